cpu_ctrl_fsm: RTL and testbench
===============================

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have parameter REG_N, default 8, meaning number of general registers; power of two, 2..16.
REQ-002 SHALL have localparam RW = $clog2(REG_N) and IW = 3+2*RW, the instruction width (9 at default).
REQ-003 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1; the one clock, asynchronous active-low reset.
REQ-005 SHALL have port run, input, 1, meaning start one instruction.
REQ-006 SHALL have port DIN, input, IW, meaning instruction word or immediate data.
REQ-007 SHALL have port g_nz, input, 1, meaning datapath G register is nonzero.
REQ-008 SHALL have port r_in, output, REG_N, meaning one-hot register write enables.
REQ-009 SHALL have port r_out, output, REG_N, meaning one-hot register bus drives.
REQ-010 SHALL have ports ir_in, a_in, g_in, g_out and din_out, each output, 1, meaning datapath load and bus-drive strobes.
REQ-011 SHALL have port alu_op, output, 2, meaning 00 add, 01 sub, 10 and.
REQ-012 SHALL have ports done, busy and illegal, each output, 1.
REQ-013 SHALL have port state, output, 3, meaning current state encoding.

Function
REQ-014 SHALL decode IR[IW-1:IW-3] as the opcode, IR[2RW-1:RW] as X and IR[RW-1:0] as Y.
REQ-015 SHALL hold the internal IR register and load it from DIN when ir_in=1.
REQ-016 SHALL use states IDLE=0, DECODE=1, MV=2, MVI=3, ALU1=4, ALU2=5, ALU3=6 and ERR=7.
REQ-017 SHALL in IDLE drive ir_in=run and go to DECODE when run=1; otherwise it stays in IDLE.
REQ-018 SHALL in DECODE assert no strobes and branch: 000 or 101 to MV, 001 to MVI, 010/011/100 to ALU1, 110/111 to ERR.
REQ-019 SHALL in MV assert r_out[Y] and r_in[X] plus done, then go to IDLE; for opcode 101 (mvnz) it asserts r_out/r_in only if g_nz=1, and still asserts done.
REQ-020 SHALL in MVI assert din_out, r_in[X] and done, then go to IDLE; DIN holds the immediate in that cycle.
REQ-021 SHALL in ALU1 assert r_out[X] and a_in.
REQ-022 SHALL in ALU2 assert r_out[Y] and g_in, with alu_op=opcode[1:0]-2'b10 mapping (010->00, 011->01, 100->10).
REQ-023 SHALL in ALU3 assert g_out, r_in[X] and done, then go to IDLE.
REQ-024 SHALL in ERR assert illegal and done for one cycle, write no register, and go to IDLE.
REQ-025 SHALL drive every strobe not listed for a state to 0, with alu_op=00 outside ALU2.
REQ-026 SHALL assert busy in every state except IDLE.
REQ-027 SHALL ignore run outside IDLE, with no queuing.
REQ-028 SHALL allow back-to-back execution: run=1 in the IDLE cycle after done starts the next instruction.
REQ-029 SHALL for X==Y write r_in[X] and r_out[X] together in MV (self-move); this is legal.
REQ-030 SHALL never have more than one bit of r_out set in any cycle.
REQ-031 SHALL drive each output only from state_reg, IR, g_nz and run; run feeds only ir_in.
REQ-032 SHALL give latencies from run-accepted edge to done: mv/mvnz/mvi 2 cycles, ERR 2, ALU 4.

Reset
REQ-033 SHALL on rst=0 immediately force state=IDLE and IR=0, asynchronously, including mid-instruction.
REQ-034 SHALL during reset drive all outputs 0 except ir_in=0.
REQ-035 SHALL resume on the first rising clk edge after rst deasserts, which samples run.

Structure
REQ-036 SHALL place state_t, opcode_t (MV, MVI, ADD, SUB, AND, MVNZ) and alu_op_t in package cpu_ctrl_pkg.
REQ-037 SHALL instantiate the parametrised one-hot decoder reg_sel_dec (RW in, REG_N out) twice, for X and Y.
REQ-038 SHALL keep the state register and IR as the only sequential elements.

Verification
REQ-039 SHALL cover: DIN=9'b000_011_101, run pulse -> in MV, r_out=8'h20, r_in=8'h08, done=1 two cycles after accept.
REQ-040 SHALL cover: DIN=9'b001_010_000, then DIN=9'h055 in MVI -> din_out=1, r_in=8'h04, done=1.
REQ-041 SHALL cover: DIN=9'b011_001_010 -> ALU1 r_out=8'h02, a_in=1; ALU2 r_out=8'h04, g_in=1, alu_op=01; ALU3 g_out=1, r_in=8'h02, done=1.
REQ-042 SHALL cover: DIN=9'b101_000_111 with g_nz=0 -> done=1, r_in=0; repeat with g_nz=1 -> r_in=8'h01, r_out=8'h80.
REQ-043 SHALL cover: DIN=9'b110_000_000 -> illegal=1 and done=1 for one cycle, no r_in, back to IDLE.
REQ-044 SHALL cover: rst=0 asserted in ALU2 -> state=0 and all strobes 0 before the next clk edge; REG_N=4 rerun of REQ-041 with IW=7.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the multicycle CPU control FSM: state encoding, opcodes,
// ALU operation codes and the opcode-to-ALU mapping.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_MV     = 3'd2,
    S_MVI    = 3'd3,
    S_ALU1   = 3'd4,
    S_ALU2   = 3'd5,
    S_ALU3   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVNZ = 3'b101
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10
  } alu_op_t;

  // ALU opcodes are contiguous from 010, so subtracting 2 yields the ALU code.
  function automatic alu_op_t alu_op_of(input logic [2:0] op);
    logic [1:0] w_code;
    w_code = op[1:0] - 2'b10;
    return alu_op_t'(w_code);
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control bundle between the FSM (slave side) and its datapath/driver (master side).
// Inputs run/DIN/g_nz are sampled on the rising clock; all strobes are level outputs.
interface cpu_ctrl_fsm_if
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_N = 8
);
  localparam int RW = $clog2(REG_N);
  localparam int IW = 3 + 2 * RW;

  logic             run;
  logic [IW-1:0]    DIN;
  logic             g_nz;
  logic [REG_N-1:0] r_in;
  logic [REG_N-1:0] r_out;
  logic             ir_in;
  logic             a_in;
  logic             g_in;
  logic             g_out;
  logic             din_out;
  alu_op_t          alu_op;
  logic             done;
  logic             busy;
  logic             illegal;
  logic [2:0]       state;

  modport slave (
    input  run, DIN, g_nz,
    output r_in, r_out, ir_in, a_in, g_in, g_out, din_out,
    output alu_op, done, busy, illegal, state
  );

  modport master (
    output run, DIN, g_nz,
    input  r_in, r_out, ir_in, a_in, g_in, g_out, din_out,
    input  alu_op, done, busy, illegal, state
  );

endinterface

// File: rtl/reg_sel_dec.sv
// Binary register index to one-hot select.
module reg_sel_dec #(
  parameter int REG_N = 8,
  parameter int RW    = $clog2(REG_N)
) (
  input  logic [RW-1:0]    i_sel,
  output logic [REG_N-1:0] o_onehot
);

  always_comb begin
    o_onehot        = '0;
    o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control FSM for a simple register-machine CPU: fetches an instruction
// word from DIN, then sequences mv/mvi/mvnz/add/sub/and with one-hot register strobes.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_N = 8
) (
  input logic              clk,
  input logic              rst,
  cpu_ctrl_fsm_if.slave    bus
);
  localparam int RW = $clog2(REG_N);
  localparam int IW = 3 + 2 * RW;

  state_t           r_state;
  logic [IW-1:0]    r_ir;

  opcode_t          w_opcode;
  logic [RW-1:0]    w_x;
  logic [RW-1:0]    w_y;
  logic [REG_N-1:0] w_x_oh;
  logic [REG_N-1:0] w_y_oh;
  logic             w_ir_in;
  logic             w_mv_en;

  assign w_opcode = opcode_t'(r_ir[IW-1 -: 3]);
  assign w_x      = r_ir[2*RW-1:RW];
  assign w_y      = r_ir[RW-1:0];
  // Gated by rst so no load strobe leaks out while reset is held with run high.
  assign w_ir_in  = (r_state == S_IDLE) && bus.run && rst;
  assign w_mv_en  = (w_opcode != OP_MVNZ) || bus.g_nz;

  reg_sel_dec #(.REG_N(REG_N), .RW(RW)) u_dec_x (.i_sel(w_x), .o_onehot(w_x_oh));
  reg_sel_dec #(.REG_N(REG_N), .RW(RW)) u_dec_y (.i_sel(w_y), .o_onehot(w_y_oh));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      if (w_ir_in) r_ir <= bus.DIN;
      case (r_state)
        S_IDLE:   if (bus.run) r_state <= S_DECODE;
        S_DECODE: begin
          case (w_opcode)
            OP_MV, OP_MVNZ:         r_state <= S_MV;
            OP_MVI:                 r_state <= S_MVI;
            OP_ADD, OP_SUB, OP_AND: r_state <= S_ALU1;
            default:                r_state <= S_ERR;
          endcase
        end
        S_ALU1:   r_state <= S_ALU2;
        S_ALU2:   r_state <= S_ALU3;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.r_in    = '0;
    bus.r_out   = '0;
    bus.ir_in   = w_ir_in;
    bus.a_in    = 1'b0;
    bus.g_in    = 1'b0;
    bus.g_out   = 1'b0;
    bus.din_out = 1'b0;
    bus.alu_op  = ALU_ADD;
    bus.done    = 1'b0;
    bus.busy    = (r_state != S_IDLE);
    bus.illegal = 1'b0;
    bus.state   = r_state;
    case (r_state)
      S_MV: begin
        // mvnz still completes when G is zero; it just moves nothing.
        if (w_mv_en) begin
          bus.r_in  = w_x_oh;
          bus.r_out = w_y_oh;
        end
        bus.done = 1'b1;
      end
      S_MVI: begin
        bus.din_out = 1'b1;
        bus.r_in    = w_x_oh;
        bus.done    = 1'b1;
      end
      S_ALU1: begin
        bus.r_out = w_x_oh;
        bus.a_in  = 1'b1;
      end
      S_ALU2: begin
        bus.r_out  = w_y_oh;
        bus.g_in   = 1'b1;
        bus.alu_op = alu_op_of(r_ir[IW-1 -: 3]);
      end
      S_ALU3: begin
        bus.g_out = 1'b1;
        bus.r_in  = w_x_oh;
        bus.done  = 1'b1;
      end
      S_ERR: begin
        bus.illegal = 1'b1;
        bus.done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: an instruction-level model predicts the output
// vector of every active cycle; a negedge monitor pops and compares.
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  localparam int W = 29;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_ctrl_fsm_if #(.REG_N(8)) bus8();
  cpu_ctrl_fsm_if #(.REG_N(4)) bus4();

  cpu_ctrl_fsm #(.REG_N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  cpu_ctrl_fsm #(.REG_N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  logic [W-1:0] mon_act, mon_exp;

  function automatic logic [W-1:0] mk(input logic [7:0] ri, input logic [7:0] ro,
                                      input logic iri, input logic ai, input logic gi,
                                      input logic go, input logic dio, input logic [1:0] alu,
                                      input logic dn, input logic bs, input logic il,
                                      input logic [2:0] st);
    return {ri, ro, iri, ai, gi, go, dio, alu, dn, bs, il, st};
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] i);
    return 8'd1 << i;
  endfunction

  function automatic logic [W-1:0] vec8();
    return {bus8.r_in, bus8.r_out, bus8.ir_in, bus8.a_in, bus8.g_in, bus8.g_out,
            bus8.din_out, bus8.alu_op, bus8.done, bus8.busy, bus8.illegal, bus8.state};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Monitor: any active cycle (load strobe, busy or done) consumes one expectation.
  always @(negedge clk) begin
    if (rst) begin
      mon_act = vec8();
      if (bus8.busy === 1'b1 || bus8.ir_in === 1'b1 || bus8.done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h expected none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL cycle_vec: got %h expected %h", mon_act, mon_exp);
          end
        end
      end
    end
  end

  task automatic push_model(input logic [8:0] din, input logic gnz, output int n);
    logic [2:0] op, x, y, t;
    logic mv;
    op = din[8:6];
    x  = din[5:3];
    y  = din[2:0];
    t  = op - 3'd2;
    exp_q.push_back(mk(8'h0, 8'h0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'd0));
    exp_q.push_back(mk(8'h0, 8'h0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 3'd1));
    case (op)
      3'd0, 3'd5: begin
        mv = (op == 3'd0) || gnz;
        exp_q.push_back(mk(mv ? oh(x) : 8'h0, mv ? oh(y) : 8'h0, 0, 0, 0, 0, 0, 2'b00,
                           1, 1, 0, 3'd2));
        n = 2;
      end
      3'd1: begin
        exp_q.push_back(mk(oh(x), 8'h0, 0, 0, 0, 0, 1, 2'b00, 1, 1, 0, 3'd3));
        n = 2;
      end
      3'd2, 3'd3, 3'd4: begin
        exp_q.push_back(mk(8'h0, oh(x), 0, 1, 0, 0, 0, 2'b00, 0, 1, 0, 3'd4));
        exp_q.push_back(mk(8'h0, oh(y), 0, 0, 1, 0, 0, t[1:0], 0, 1, 0, 3'd5));
        exp_q.push_back(mk(oh(x), 8'h0, 0, 0, 0, 1, 0, 2'b00, 1, 1, 0, 3'd6));
        n = 4;
      end
      default: begin
        exp_q.push_back(mk(8'h0, 8'h0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 1, 3'd7));
        n = 2;
      end
    endcase
  endtask

  // Called just after a rising edge with the FSM in IDLE; returns in IDLE.
  task automatic issue(input logic [8:0] din, input logic gnz, input int gap);
    int n;
    push_model(din, gnz, n);
    bus8.DIN  = din;
    bus8.g_nz = gnz;
    bus8.run  = 1'b1;
    @(posedge clk); #1;
    repeat (n) begin
      bus8.run = 1'($urandom_range(0, 1));
      bus8.DIN = 9'($urandom);
      @(posedge clk); #1;
    end
    bus8.run = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_in_alu2();
    logic [8:0] din;
    logic [W-1:0] dummy;
    din = {3'b010, 3'($urandom), 3'($urandom)};
    exp_q.push_back(mk(8'h0, 8'h0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'd0));
    exp_q.push_back(mk(8'h0, 8'h0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 3'd1));
    exp_q.push_back(mk(8'h0, oh(din[5:3]), 0, 1, 0, 0, 0, 2'b00, 0, 1, 0, 3'd4));
    bus8.DIN = din;
    bus8.run = 1'b1;
    @(posedge clk); #1;
    bus8.run = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_alu2_state", bus8.state, 3'd5);
    bus8.run = 1'b1;
    rst = 1'b0;
    #1;
    dummy = vec8();
    chk("async_reset_mid_alu2", dummy, '0);
    @(posedge clk); #1;
    dummy = vec8();
    chk("reset_held_outputs", dummy, '0);
    bus8.run = 1'b0;
    rst = 1'b1;
  endtask

  task automatic run_reg4();
    bus4.DIN = 7'b011_01_10;
    bus4.run = 1'b1;
    #1;
    chk("r4_accept_ir_in", bus4.ir_in, 1);
    @(posedge clk); #1;
    bus4.run = 1'b0;
    chk("r4_decode_state", bus4.state, 3'd1);
    @(posedge clk); #1;
    chk("r4_alu1_r_out", bus4.r_out, 4'h2);
    chk("r4_alu1_a_in", bus4.a_in, 1);
    @(posedge clk); #1;
    chk("r4_alu2_r_out", bus4.r_out, 4'h4);
    chk("r4_alu2_g_in", bus4.g_in, 1);
    chk("r4_alu2_alu_op", bus4.alu_op, 2'b01);
    @(posedge clk); #1;
    chk("r4_alu3_g_out", bus4.g_out, 1);
    chk("r4_alu3_r_in", bus4.r_in, 4'h2);
    chk("r4_alu3_done", bus4.done, 1);
    @(posedge clk); #1;
    chk("r4_back_idle_busy", bus4.busy, 0);
    chk("r4_back_idle_state", bus4.state, 3'd0);
  endtask

  initial begin
    logic [W-1:0] v;
    bus8.run = 1'b1; bus8.DIN = 9'h1ff; bus8.g_nz = 1'b1;
    bus4.run = 1'b1; bus4.DIN = 7'h7f;  bus4.g_nz = 1'b1;
    #1;
    v = vec8();
    chk("reset_outputs_8", v, '0);
    chk("reset_ir_in_4", bus4.ir_in, 0);
    repeat (2) @(posedge clk);
    #1;
    v = vec8();
    chk("reset_held_clocked_8", v, '0);
    bus8.run = 1'b0;
    bus4.run = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    run_reg4();

    issue(9'b000_011_101, 1'b0, 1);
    issue(9'b001_010_000, 1'b0, 0);
    issue(9'b011_001_010, 1'b0, 0);
    issue(9'b101_000_111, 1'b0, 1);
    issue(9'b101_000_111, 1'b1, 0);
    issue(9'b110_000_000, 1'b0, 0);
    issue(9'b111_101_011, 1'b1, 2);
    issue(9'b000_100_100, 1'b0, 0);
    issue(9'b100_110_001, 1'b0, 0);
    issue(9'b010_111_000, 1'b1, 1);

    reset_in_alu2();
    @(posedge clk); #1;

    repeat (200) issue(9'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
